// File: rtl/id_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_stage_pkg
// Shared parameter file for the 19-bit CPU datapath. It holds the opcode
// codes used by both the ALU and the decode stage, the datapath widths, and
// the operand-class decode that tells the ID stage which operands an opcode
// consumes.
// ---------------------------------------------------------------------------
package id_stage_pkg;

    localparam int XLEN  = 19;  // datapath width
    localparam int RA_W  = 3;   // register index width (fixed)
    localparam int OP_W  = 5;   // opcode / ALU control width

    // Opcode field doubles as the ALU control code.
    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL   = 5'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 5'd3;
    localparam logic [OP_W-1:0] OP_AND   = 5'd4;
    localparam logic [OP_W-1:0] OP_OR    = 5'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd6;
    localparam logic [OP_W-1:0] OP_INC   = 5'd7;
    localparam logic [OP_W-1:0] OP_DEC   = 5'd8;
    localparam logic [OP_W-1:0] OP_NOT   = 5'd9;
    localparam logic [OP_W-1:0] OP_ENCRY = 5'd10;
    localparam logic [OP_W-1:0] OP_DECRY = 5'd11;
    localparam logic [OP_W-1:0] OP_IMMED = 5'd12;

    // Which operands an opcode consumes.
    typedef enum logic [1:0] {
        CLS_RR  = 2'd0,  // in1 = R[rs1], in2 = R[rs2]
        CLS_R   = 2'd1,  // in1 = R[rs1], in2 = 0
        CLS_IMM = 2'd2,  // in1 = 0,      in2 = zero-extended imm
        CLS_ILL = 2'd3   // undefined opcode: both operands 0, no write
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_AND, OP_OR,  OP_XOR:                   return CLS_RR;
            OP_INC, OP_DEC, OP_NOT, OP_ENCRY, OP_DECRY: return CLS_R;
            OP_IMMED:                                  return CLS_IMM;
            default:                                   return CLS_ILL;
        endcase
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op_class(op) != CLS_ILL;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// ---------------------------------------------------------------------------
// regfile
// NREG x XLEN register file: one synchronous write port, two asynchronous
// read ports, synchronous active-low clear of every entry. No register is
// hardwired to zero.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low clear
//   we, waddr, wdata  write port (takes effect at the rising edge)
//   raddr1, rdata1    async read port 1
//   raddr2, rdata2    async read port 2
// ---------------------------------------------------------------------------
module regfile
    import id_stage_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RA_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREG];

    // NOTE: this array is cleared by reset because the architecture defines
    // every register as 0 after reset; that keeps it in flops rather than a
    // RAM macro, which is acceptable at 8 entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction-decode stage. Accepts instructions from fetch, reads the
// register file with EX/WB forwarding, and issues in1/in2/alu_ctrl plus the
// destination tag to the ALU through a registered ID/EX entry with
// valid/ready flow control.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   flush                           drop the held ID/EX entry
//   in_valid, in_ready, instr       fetch handshake and instruction
//   ex_fwd_valid/_rd/_data          EX-stage result forward
//   wb_we, wb_rd, wb_data           writeback (regfile write + bypass)
//   out_valid, out_ready            ID/EX handshake to EX
//   in1, in2, alu_ctrl              ALU operands and operation
//   out_rd, out_we, illegal         destination tag, write enable, bad opcode
// ---------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int IMM_W = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic            ex_fwd_valid,
    input  logic [RA_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic [OP_W-1:0] alu_ctrl,
    output logic [RA_W-1:0] out_rd,
    output logic            out_we,
    output logic            illegal
);

    // Instruction fields.
    logic [OP_W-1:0]  opcode;
    logic [RA_W-1:0]  rd, rs1, rs2;
    logic [XLEN-1:0]  imm_ext;

    assign opcode  = instr[18:14];
    assign rd      = instr[13:11];
    assign rs1     = instr[10:8];
    assign rs2     = instr[7:5];
    assign imm_ext = {{(XLEN-IMM_W){1'b0}}, instr[IMM_W-1:0]};

    logic [XLEN-1:0] rf_rdata1, rf_rdata2;

    regfile #(.NREG(NREG)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2)
    );

    // EX result is younger than WB, so it wins; WB bypasses the write that
    // lands in the file at the same edge.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf_val,
        input logic            exv,
        input logic [RA_W-1:0] exrd,
        input logic [XLEN-1:0] exd,
        input logic            wbv,
        input logic [RA_W-1:0] wbrd,
        input logic [XLEN-1:0] wbd
    );
        if (exv && exrd == rs)      return exd;
        else if (wbv && wbrd == rs) return wbd;
        else                        return rf_val;
    endfunction

    logic [XLEN-1:0] src1, src2;
    assign src1 = resolve(rs1, rf_rdata1, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          wb_we, wb_rd, wb_data);
    assign src2 = resolve(rs2, rf_rdata2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          wb_we, wb_rd, wb_data);

    // Operand decode for the instruction currently presented by fetch.
    op_class_e       cls;
    logic [XLEN-1:0] nxt_in1, nxt_in2;

    assign cls = op_class(opcode);

    // NOTE: every signal written in this always_comb gets a default first so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        nxt_in1 = '0;
        nxt_in2 = '0;
        case (cls)
            CLS_RR:  begin nxt_in1 = src1; nxt_in2 = src2;    end
            CLS_R:   begin nxt_in1 = src1;                    end
            CLS_IMM: begin                 nxt_in2 = imm_ext; end
            default: ;
        endcase
    end

    // Flush blocks acceptance so the instruction behind it is not captured.
    logic accept;
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ID/EX register. Priority: reset > flush > accept > consume > hold.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in1       <= '0;
            in2       <= '0;
            alu_ctrl  <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            in1       <= nxt_in1;
            in2       <= nxt_in2;
            alu_ctrl  <= opcode;
            out_rd    <= rd;
            out_we    <= (cls != CLS_ILL);
            illegal   <= (cls == CLS_ILL);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
